// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - request/response and memory-side bus of the unified memory arbiter
interface unified_mem_arbiter_if;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_addr;
   logic        if_resp_valid;
   logic        if_resp_ready;
   logic [31:0] if_instr;
   logic        if_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_resp_valid;
   logic        d_resp_ready;
   logic [63:0] d_rdata;
   logic        d_err;
   logic        MemRead;
   logic        MemWrite;
   logic        IorD;
   logic [63:0] pc_addr;
   logic [63:0] data_addr;
   logic [63:0] write_data;
   logic [31:0] instruction;
   logic [63:0] read_data;

   // Arbiter side
   modport slave (
      input  if_req_valid, if_addr, if_resp_ready,
      input  d_req_valid, d_req_we, d_addr, d_wdata, d_resp_ready,
      input  instruction, read_data,
      output if_req_ready, if_resp_valid, if_instr, if_err,
      output d_req_ready, d_resp_valid, d_rdata, d_err,
      output MemRead, MemWrite, IorD, pc_addr, data_addr, write_data
   );

   // Requester and memory side
   modport master (
      output if_req_valid, if_addr, if_resp_ready,
      output d_req_valid, d_req_we, d_addr, d_wdata, d_resp_ready,
      output instruction, read_data,
      input  if_req_ready, if_resp_valid, if_instr, if_err,
      input  d_req_ready, d_resp_valid, d_rdata, d_err,
      input  MemRead, MemWrite, IorD, pc_addr, data_addr, write_data
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter owning the unified memory port
// One access at a time: IDLE accepts a winner, ACCESS strobes memory for one cycle,
// RESP holds the registered response until the owner takes it.
module unified_mem_arbiter #(
   parameter int MEM_SIZE     = 12288,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   unified_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0]  LP_LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [64:0] LP_MEM_END = 65'(MEM_SIZE);

   state_t      r_state;
   logic [3:0]  r_starve;
   logic        r_is_data;
   logic        r_we;
   logic        r_fault;
   logic        r_if_req_ready;
   logic        r_d_req_ready;
   logic        r_if_resp_valid;
   logic [31:0] r_if_instr;
   logic        r_if_err;
   logic        r_d_resp_valid;
   logic [63:0] r_d_rdata;
   logic        r_d_err;
   logic        r_mem_read;
   logic        r_mem_write;
   logic        r_iord;
   logic [63:0] r_pc_addr;
   logic [63:0] r_data_addr;
   logic [63:0] r_write_data;

   logic        w_fetch_starved;
   logic        w_grant_d;
   logic        w_grant_f;
   logic [63:0] w_win_addr;
   logic        w_win_we;
   logic [64:0] w_end;
   logic        w_misalign;
   logic        w_fault;
   logic        w_resp_done;

   // Data normally wins; a fetch that has lost too often takes priority.
   assign w_fetch_starved = bus.if_req_valid && (r_starve >= LP_LIMIT);
   assign w_grant_d       = bus.d_req_valid && !w_fetch_starved;
   assign w_grant_f       = bus.if_req_valid && !w_grant_d;
   assign w_win_addr      = w_grant_d ? bus.d_addr : bus.if_addr;
   assign w_win_we        = w_grant_d && bus.d_req_we;

   // Fault is evaluated on the request as it is latched; 65-bit end address so
   // addresses near 2^64 cannot wrap back into range.
   assign w_end       = {1'b0, w_win_addr} + (w_grant_d ? 65'd8 : 65'd4);
   assign w_misalign  = w_grant_d ? (w_win_addr[2:0] != 3'd0) : (w_win_addr[1:0] != 2'd0);
   assign w_fault     = w_misalign || (w_end > LP_MEM_END);
   assign w_resp_done = (r_if_resp_valid && bus.if_resp_ready) ||
                        (r_d_resp_valid && bus.d_resp_ready);

   // Control FSM with all outputs registered; reset drops strobes immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_starve        <= 4'd0;
         r_is_data       <= 1'b0;
         r_we            <= 1'b0;
         r_fault         <= 1'b0;
         r_if_req_ready  <= 1'b1;
         r_d_req_ready   <= 1'b1;
         r_if_resp_valid <= 1'b0;
         r_if_instr      <= 32'd0;
         r_if_err        <= 1'b0;
         r_d_resp_valid  <= 1'b0;
         r_d_rdata       <= 64'd0;
         r_d_err         <= 1'b0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_iord          <= 1'b0;
         r_pc_addr       <= 64'd0;
         r_data_addr     <= 64'd0;
         r_write_data    <= 64'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!bus.if_req_valid || w_grant_f) begin
                  r_starve <= 4'd0;
               end else if (r_starve != 4'd15) begin
                  r_starve <= r_starve + 4'd1;
               end
               if (w_grant_d || w_grant_f) begin
                  r_is_data      <= w_grant_d;
                  r_we           <= w_win_we;
                  r_fault        <= w_fault;
                  r_mem_read     <= !w_fault && !w_win_we;
                  r_mem_write    <= !w_fault && w_win_we;
                  r_iord         <= w_grant_d;
                  r_pc_addr      <= (w_grant_f && !w_fault) ? bus.if_addr : 64'd0;
                  r_data_addr    <= (w_grant_d && !w_fault) ? bus.d_addr : 64'd0;
                  r_write_data   <= (w_win_we && !w_fault) ? bus.d_wdata : 64'd0;
                  r_if_req_ready <= 1'b0;
                  r_d_req_ready  <= 1'b0;
                  r_state        <= ACCESS;
               end
            end
            ACCESS: begin
               r_mem_read   <= 1'b0;
               r_mem_write  <= 1'b0;
               r_iord       <= 1'b0;
               r_pc_addr    <= 64'd0;
               r_data_addr  <= 64'd0;
               r_write_data <= 64'd0;
               if (r_is_data) begin
                  r_d_resp_valid <= 1'b1;
                  r_d_err        <= r_fault;
                  r_d_rdata      <= (r_fault || r_we) ? 64'd0 : bus.read_data;
               end else begin
                  r_if_resp_valid <= 1'b1;
                  r_if_err        <= r_fault;
                  r_if_instr      <= r_fault ? 32'd0 : bus.instruction;
               end
               r_state <= RESP;
            end
            RESP: begin
               if (w_resp_done) begin
                  r_if_resp_valid <= 1'b0;
                  r_d_resp_valid  <= 1'b0;
                  r_if_req_ready  <= 1'b1;
                  r_d_req_ready   <= 1'b1;
                  r_state         <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.if_req_ready  = r_if_req_ready;
   assign bus.d_req_ready   = r_d_req_ready;
   assign bus.if_resp_valid = r_if_resp_valid;
   assign bus.if_instr      = r_if_instr;
   assign bus.if_err        = r_if_err;
   assign bus.d_resp_valid  = r_d_resp_valid;
   assign bus.d_rdata       = r_d_rdata;
   assign bus.d_err         = r_d_err;
   assign bus.MemRead       = r_mem_read;
   assign bus.MemWrite      = r_mem_write;
   assign bus.IorD          = r_iord;
   assign bus.pc_addr       = r_pc_addr;
   assign bus.data_addr     = r_data_addr;
   assign bus.write_data    = r_write_data;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
   localparam int MEM_SIZE     = 12288;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_init;
   logic [31:0] seed;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          viol    = 0;
   int          wr_cnt  = 0;
   logic [63:0] mem64 [0:2047];
   logic [63:0] ref64 [0:2047];
   logic [63:0] w_iword;

   unified_mem_arbiter_if bus();

   unified_mem_arbiter #(.MEM_SIZE(MEM_SIZE), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] init_word(int i, logic [31:0] s);
      logic [63:0] w;
      w = {s ^ (i * 32'h9E3779B9), ~s + (i * 32'h85EBCA6B)};
      if (i == 0) w[31:0] = 32'h00500093;
      return w;
   endfunction

   // Unified memory: combinational reads, write on the edge when MemWrite is high
   assign bus.read_data   = (bus.data_addr < 64'(MEM_SIZE)) ? mem64[bus.data_addr[13:3]] : 64'd0;
   assign w_iword         = (bus.pc_addr < 64'(MEM_SIZE)) ? mem64[bus.pc_addr[13:3]] : 64'd0;
   assign bus.instruction = bus.pc_addr[2] ? w_iword[63:32] : w_iword[31:0];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 2048; i++) mem64[i] <= init_word(i, seed);
      end else if (bus.MemWrite && bus.data_addr < 64'(MEM_SIZE)) begin
         mem64[bus.data_addr[13:3]] <= bus.write_data;
      end
   end

   always @(posedge clk) if (bus.MemWrite) wr_cnt <= wr_cnt + 1;

   always @(negedge clk)
      if ((bus.MemRead && bus.MemWrite) || (bus.if_resp_valid && bus.d_resp_valid)) viol <= viol + 1;

   // Reference model: access rules stated directly in terms of byte ranges
   function automatic bit ref_fault(bit is_d, logic [63:0] a);
      if (is_d) return (a % 64'd8 != 64'd0) || (a > 64'(MEM_SIZE - 8));
      return (a % 64'd4 != 64'd0) || (a > 64'(MEM_SIZE - 4));
   endfunction

   function automatic logic [63:0] ref_expect(bit is_d, bit we, logic [63:0] a);
      logic [63:0] w;
      if (ref_fault(is_d, a) || (is_d && we)) return 64'd0;
      w = ref64[int'(a / 64'd8)];
      if (is_d) return w;
      return (a % 64'd8 == 64'd4) ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
   endfunction

   function automatic void ref_store(logic [63:0] a, logic [63:0] d);
      if (!ref_fault(1'b1, a)) ref64[int'(a / 64'd8)] = d;
   endfunction

   function automatic logic [63:0] gen_addr(bit is_d);
      case ($urandom_range(0, 9))
         0: return 64'($urandom_range(0, MEM_SIZE - 1)) | 64'd1;
         1: return 64'(MEM_SIZE - 4);
         2: return 64'hFFFF_FFFF_FFFF_FFF8;
         3: return 64'(MEM_SIZE - 8);
         default: return is_d ? 64'($urandom_range(0, MEM_SIZE / 8 - 1)) * 8
                              : 64'($urandom_range(0, MEM_SIZE / 4 - 1)) * 4;
      endcase
   endfunction

   task automatic single_access(input bit is_d, input bit we, input logic [63:0] addr,
                                input logic [63:0] wd, output logic [63:0] data,
                                output logic err, output int lat, output logic s_rd,
                                output logic s_wr, output logic s_iord);
      @(negedge clk);
      if (is_d) begin
         bus.d_req_valid = 1'b1; bus.d_req_we = we; bus.d_addr = addr; bus.d_wdata = wd;
      end else begin
         bus.if_req_valid = 1'b1; bus.if_addr = addr;
      end
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0; bus.d_req_we = 1'b0;
      @(negedge clk);
      s_rd = bus.MemRead; s_wr = bus.MemWrite; s_iord = bus.IorD;
      lat = 1;
      while (lat < 12) begin
         @(negedge clk);
         lat++;
         if (is_d ? bus.d_resp_valid : bus.if_resp_valid) break;
      end
      data = is_d ? bus.d_rdata : {32'd0, bus.if_instr};
      err  = is_d ? bus.d_err : bus.if_err;
      bus.d_resp_ready = 1'b1; bus.if_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.d_resp_ready = 1'b0; bus.if_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int wc0;
      @(negedge clk);
      n_tests++; if ({bus.if_req_ready, bus.d_req_ready} !== 2'b11) begin n_fail++;
         $display("FAIL reset_ready: got %b expected 11", {bus.if_req_ready, bus.d_req_ready}); end
      n_tests++; if ({bus.MemRead, bus.MemWrite, bus.IorD} !== 3'b000) begin n_fail++;
         $display("FAIL reset_strobes: got %b expected 000", {bus.MemRead, bus.MemWrite, bus.IorD}); end
      n_tests++; if ({bus.if_resp_valid, bus.d_resp_valid, bus.if_err, bus.d_err} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_resp: got %b expected 0000", {bus.if_resp_valid, bus.d_resp_valid, bus.if_err, bus.d_err}); end
      n_tests++; if ((bus.pc_addr | bus.data_addr | bus.write_data | bus.d_rdata) !== 64'd0 || bus.if_instr !== 32'd0) begin n_fail++;
         $display("FAIL reset_buses: pc %h da %h wd %h rd %h in %h expected all 0", bus.pc_addr, bus.data_addr, bus.write_data, bus.d_rdata, bus.if_instr); end
      wc0 = wr_cnt;
      bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_addr = 64'h1000; bus.d_wdata = 64'h1122334455667788;
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0;
      n_tests++; if (bus.MemWrite !== 1'b1) begin n_fail++;
         $display("FAIL reset_store_access: MemWrite got %b expected 1", bus.MemWrite); end
      #2 reset = 1'b1;
      #1;
      n_tests++; if (bus.MemWrite !== 1'b0) begin n_fail++;
         $display("FAIL reset_strobe_drop: MemWrite got %b expected 0", bus.MemWrite); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_tests++; if (mem64[512] !== ref64[512] || wr_cnt !== wc0) begin n_fail++;
         $display("FAIL reset_no_write: mem %h expected %h, writes %0d expected %0d", mem64[512], ref64[512], wr_cnt, wc0); end
      n_tests++; if ({bus.if_req_ready, bus.d_req_ready, bus.d_resp_valid} !== 3'b110) begin n_fail++;
         $display("FAIL reset_release: got %b expected 110", {bus.if_req_ready, bus.d_req_ready, bus.d_resp_valid}); end
   endtask

   task automatic test_single_fetch();
      logic [63:0] d; logic e, rd, wr, io; int lat;
      single_access(1'b0, 1'b0, 64'h0, 64'h0, d, e, lat, rd, wr, io);
      n_tests++; if ({io, rd, wr} !== 3'b010) begin n_fail++;
         $display("FAIL fetch_access: IorD/MemRead/MemWrite got %b expected 010", {io, rd, wr}); end
      n_tests++; if (lat !== 2) begin n_fail++;
         $display("FAIL fetch_latency: got %0d expected 2", lat); end
      n_tests++; if (d !== 64'h00500093 || e !== 1'b0) begin n_fail++;
         $display("FAIL fetch_data: got %h err %b expected 00500093 err 0", d, e); end
   endtask

   task automatic test_store_load();
      logic [63:0] d; logic e, rd, wr, io; int lat;
      single_access(1'b1, 1'b1, 64'h1008, 64'hDEADBEEF_CAFEF00D, d, e, lat, rd, wr, io);
      ref_store(64'h1008, 64'hDEADBEEF_CAFEF00D);
      n_tests++; if ({io, rd, wr} !== 3'b101 || lat !== 2) begin n_fail++;
         $display("FAIL store_access: IorD/MemRead/MemWrite got %b lat %0d expected 101 lat 2", {io, rd, wr}, lat); end
      n_tests++; if (d !== 64'd0 || e !== 1'b0) begin n_fail++;
         $display("FAIL store_resp: got %h err %b expected 0 err 0", d, e); end
      single_access(1'b1, 1'b0, 64'h1008, 64'h0, d, e, lat, rd, wr, io);
      n_tests++; if ({io, rd, wr} !== 3'b110 || lat !== 2) begin n_fail++;
         $display("FAIL load_access: IorD/MemRead/MemWrite got %b lat %0d expected 110 lat 2", {io, rd, wr}, lat); end
      n_tests++; if (d !== 64'hDEADBEEF_CAFEF00D || e !== 1'b0) begin n_fail++;
         $display("FAIL load_data: got %h err %b expected deadbeefcafef00d err 0", d, e); end
   endtask

   task automatic test_faults();
      logic [63:0] a_tab [8] = '{64'h1004, 64'h2FFC, 64'h2FFE, 64'h2FFC,
                                 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2FF8, 64'h2FFC};
      bit d_tab [8] = '{1, 1, 0, 1, 1, 0, 1, 0};
      bit w_tab [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
      logic [63:0] d, exp_d; logic e, rd, wr, io, exp_e; int lat, wc0;
      for (int k = 0; k < 8; k++) begin
         exp_e = ref_fault(d_tab[k], a_tab[k]);
         exp_d = ref_expect(d_tab[k], w_tab[k], a_tab[k]);
         wc0 = wr_cnt;
         single_access(d_tab[k], w_tab[k], a_tab[k], 64'hA5A5_5A5A_0F0F_F0F0, d, e, lat, rd, wr, io);
         n_tests++; if (e !== exp_e || d !== exp_d) begin n_fail++;
            $display("FAIL fault_resp[%0d]: got %h err %b expected %h err %b", k, d, e, exp_d, exp_e); end
         n_tests++; if (rd !== (!exp_e && !w_tab[k]) || wr !== 1'b0 || wr_cnt !== wc0) begin n_fail++;
            $display("FAIL fault_strobes[%0d]: MemRead %b MemWrite %b writes %0d expected %b 0 %0d", k, rd, wr, wr_cnt, !exp_e && !w_tab[k], wc0); end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp_d; int cyc;
      exp_d = ref_expect(1'b1, 1'b0, 64'h1008);
      @(negedge clk);
      bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_addr = 64'h1008;
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0;
      cyc = 0;
      while (cyc < 10) begin
         @(negedge clk); cyc++;
         if (bus.d_resp_valid) break;
      end
      n_tests++; if (bus.d_resp_valid !== 1'b1) begin n_fail++;
         $display("FAIL bp_resp_timeout: d_resp_valid got %b expected 1", bus.d_resp_valid); end
      bus.if_req_valid = 1'b1; bus.if_addr = 64'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_tests++; if (bus.d_resp_valid !== 1'b1 || bus.d_rdata !== exp_d) begin n_fail++;
            $display("FAIL bp_hold[%0d]: valid %b data %h expected 1 %h", k, bus.d_resp_valid, bus.d_rdata, exp_d); end
         n_tests++; if ({bus.if_req_ready, bus.d_req_ready, bus.MemRead, bus.MemWrite} !== 4'b0000) begin n_fail++;
            $display("FAIL bp_quiet[%0d]: ready/strobes got %b expected 0000", k, {bus.if_req_ready, bus.d_req_ready, bus.MemRead, bus.MemWrite}); end
      end
      bus.if_req_valid = 1'b0;
      bus.d_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.d_resp_ready = 1'b0;
      n_tests++; if (bus.d_resp_valid !== 1'b0) begin n_fail++;
         $display("FAIL bp_release: d_resp_valid got %b expected 0", bus.d_resp_valid); end
      @(negedge clk);
      n_tests++; if ({bus.if_req_ready, bus.d_req_ready} !== 2'b11) begin n_fail++;
         $display("FAIL bp_idle: ready got %b expected 11", {bus.if_req_ready, bus.d_req_ready}); end
   endtask

   task automatic test_contention();
      bit exp_q[$]; bit got_q[$]; int cnt, cyc;
      cnt = 0;
      for (int g = 0; g < 10; g++) begin
         if (cnt >= STARVE_LIMIT) begin exp_q.push_back(1'b0); cnt = 0; end
         else begin exp_q.push_back(1'b1); cnt = (cnt < 15) ? cnt + 1 : 15; end
      end
      @(negedge clk);
      bus.if_resp_ready = 1'b1; bus.d_resp_ready = 1'b1;
      bus.if_addr = 64'h100; bus.d_addr = 64'h1008; bus.d_req_we = 1'b0;
      bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
      cyc = 0;
      while (got_q.size() < 10 && cyc < 80) begin
         @(negedge clk); cyc++;
         if (bus.MemRead || bus.MemWrite) got_q.push_back(bus.IorD);
      end
      bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
      n_tests++; if (got_q.size() != 10) begin n_fail++;
         $display("FAIL contention_count: got %0d grants expected 10", got_q.size()); end
      for (int g = 0; g < got_q.size(); g++) begin
         n_tests++; if (got_q[g] !== exp_q[g]) begin n_fail++;
            $display("FAIL contention_grant[%0d]: IorD got %b expected %b", g, got_q[g], exp_q[g]); end
      end
      repeat (4) @(negedge clk);
      bus.if_resp_ready = 1'b0; bus.d_resp_ready = 1'b0;
   endtask

   task automatic test_random();
      bit fpend, dpend, dwe, win_d, exp_e, got_e;
      logic [63:0] fa, da, dwd, exp_d, got_d;
      int cnt, cyc;
      fpend = 1'b0; dpend = 1'b0; cnt = 0;
      fa = 64'd0; da = 64'd0; dwe = 1'b0; dwd = 64'd0;
      for (int r = 0; r < 40; r++) begin
         if (!fpend) begin fpend = 1'($urandom_range(0, 1)); fa = gen_addr(1'b0); end
         if (!dpend) begin
            dpend = 1'($urandom_range(0, 1)); da = gen_addr(1'b1);
            dwe = 1'($urandom_range(0, 1)); dwd = {$urandom, $urandom};
         end
         if (!fpend && !dpend) dpend = 1'b1;
         @(negedge clk);
         n_tests++; if ({bus.if_req_ready, bus.d_req_ready} !== 2'b11) begin n_fail++;
            $display("FAIL rand_ready[%0d]: got %b expected 11", r, {bus.if_req_ready, bus.d_req_ready}); end
         bus.if_req_valid = fpend; bus.if_addr = fa;
         bus.d_req_valid = dpend; bus.d_addr = da; bus.d_req_we = dwe; bus.d_wdata = dwd;
         win_d = dpend && !(fpend && cnt >= STARVE_LIMIT);
         if (fpend && win_d) cnt = (cnt < 15) ? cnt + 1 : 15;
         else cnt = 0;
         exp_e = ref_fault(win_d, win_d ? da : fa);
         exp_d = ref_expect(win_d, win_d && dwe, win_d ? da : fa);
         if (win_d && dwe) ref_store(da, dwd);
         @(posedge clk); #1;
         if (win_d) begin bus.d_req_valid = 1'b0; dpend = 1'b0; end
         else begin bus.if_req_valid = 1'b0; fpend = 1'b0; end
         cyc = 0;
         while (cyc < 10) begin
            @(negedge clk); cyc++;
            if (bus.if_resp_valid || bus.d_resp_valid) break;
         end
         n_tests++; if (bus.d_resp_valid !== win_d || bus.if_resp_valid !== !win_d) begin n_fail++;
            $display("FAIL rand_src[%0d]: if/d resp_valid got %b%b expected %b%b", r, bus.if_resp_valid, bus.d_resp_valid, !win_d, win_d); end
         got_d = win_d ? bus.d_rdata : {32'd0, bus.if_instr};
         got_e = win_d ? bus.d_err : bus.if_err;
         n_tests++; if (got_d !== exp_d || got_e !== exp_e) begin n_fail++;
            $display("FAIL rand_resp[%0d]: got %h err %b expected %h err %b", r, got_d, got_e, exp_d, exp_e); end
         bus.if_resp_ready = 1'b1; bus.d_resp_ready = 1'b1;
         @(posedge clk); #1;
         bus.if_resp_ready = 1'b0; bus.d_resp_ready = 1'b0;
         bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
         if (cyc >= 10) break;
      end
   endtask

   task automatic test_invariants();
      @(negedge clk);
      n_tests++; if (viol !== 0) begin n_fail++;
         $display("FAIL exclusivity: got %0d violating cycles expected 0", viol); end
   endtask

   initial begin
      seed = $urandom;
      reset = 1'b1; mem_init = 1'b1;
      bus.if_req_valid = 1'b0; bus.if_addr = 64'd0; bus.if_resp_ready = 1'b0;
      bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_addr = 64'd0;
      bus.d_wdata = 64'd0; bus.d_resp_ready = 1'b0;
      for (int i = 0; i < 2048; i++) ref64[i] = init_word(i, seed);
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0; reset = 1'b0;
      test_reset();
      test_single_fetch();
      test_store_load();
      test_faults();
      test_backpressure();
      test_contention();
      test_random();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
